// File: rtl/mem_pkg.sv
// mem_pkg: channel state encoding and default widths for the memory controller
package mem_pkg;
    localparam int DEF_ADDR_BITS     = 8;
    localparam int DEF_DATA_BITS     = 16;
    localparam int DEF_NUM_CONSUMERS = 4;
    localparam int DEF_NUM_CHANNELS  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_WAIT,
        S_WRITE_WAIT,
        S_READ_RELAY,
        S_WRITE_RELAY
    } ch_state_e;

    function automatic int idx_bits(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mem_ctrl_channel.sv
// mem_ctrl_channel: one channel's request/relay FSM with registered memory-side outputs
module mem_ctrl_channel
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    localparam int IW           = idx_bits(NUM_CONSUMERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 claim_i,
    input  logic                 claim_rd_i,
    input  logic [IW-1:0]        claim_idx_i,
    input  logic [ADDR_BITS-1:0] claim_addr_i,
    input  logic [DATA_BITS-1:0] claim_data_i,
    input  logic                 mem_read_ready_i,
    input  logic                 mem_write_ready_i,
    input  logic                 cons_read_valid_i,
    input  logic                 cons_write_valid_i,
    output ch_state_e            state_o,
    output logic [IW-1:0]        ptr_o,
    output logic [IW-1:0]        idx_o,
    output logic                 mem_read_valid_o,
    output logic                 mem_write_valid_o,
    output logic [ADDR_BITS-1:0] mem_read_address_o,
    output logic [ADDR_BITS-1:0] mem_write_address_o,
    output logic [DATA_BITS-1:0] mem_write_data_o,
    output logic                 read_ready_o,
    output logic                 write_ready_o
);
    ch_state_e            state_q;
    logic [IW-1:0]        ptr_q, ptr_d, idx_q;
    logic                 rd_valid_q, wr_valid_q, rd_rdy_q, wr_rdy_q;
    logic [ADDR_BITS-1:0] rd_addr_q, wr_addr_q;
    logic [DATA_BITS-1:0] wr_data_q;

    assign ptr_d = IW'((int'(claim_idx_i) + 1) % NUM_CONSUMERS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_rdy_q   <= 1'b0;
            wr_rdy_q   <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (claim_i) begin
                    idx_q      <= claim_idx_i;
                    ptr_q      <= ptr_d;
                    state_q    <= claim_rd_i ? S_READ_WAIT : S_WRITE_WAIT;
                    rd_valid_q <= claim_rd_i;
                    wr_valid_q <= !claim_rd_i;
                    if (claim_rd_i) rd_addr_q <= claim_addr_i;
                    else begin
                        wr_addr_q <= claim_addr_i;
                        wr_data_q <= claim_data_i;
                    end
                end
                S_READ_WAIT: if (mem_read_ready_i) begin
                    rd_valid_q <= 1'b0;
                    rd_rdy_q   <= 1'b1;
                    state_q    <= S_READ_RELAY;
                end
                S_WRITE_WAIT: if (mem_write_ready_i) begin
                    wr_valid_q <= 1'b0;
                    wr_rdy_q   <= 1'b1;
                    state_q    <= S_WRITE_RELAY;
                end
                // hold ready until the consumer acknowledges by dropping valid
                S_READ_RELAY: if (!cons_read_valid_i) begin
                    rd_rdy_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                S_WRITE_RELAY: if (!cons_write_valid_i) begin
                    wr_rdy_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_o             = state_q;
    assign ptr_o               = ptr_q;
    assign idx_o               = idx_q;
    assign mem_read_valid_o    = rd_valid_q;
    assign mem_write_valid_o   = wr_valid_q;
    assign mem_read_address_o  = rd_addr_q;
    assign mem_write_address_o = wr_addr_q;
    assign mem_write_data_o    = wr_data_q;
    assign read_ready_o        = rd_rdy_q;
    assign write_ready_o       = wr_rdy_q;
endmodule

// File: rtl/mem_controller.sv
// mem_controller: round-robin arbitration of consumer requests onto independent memory channels
module mem_controller
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);
    localparam int IW = idx_bits(NUM_CONSUMERS);

    ch_state_e                   state [NUM_CHANNELS];
    logic [IW-1:0]               ptr [NUM_CHANNELS], idx [NUM_CHANNELS], claim_idx [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]        claim_addr [NUM_CHANNELS];
    logic [DATA_BITS-1:0]        claim_data [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]     claim, claim_rd, ch_rd_rdy, ch_wr_rdy, ch_mwv;
    logic [NUM_CHANNELS*ADDR_BITS-1:0] ch_mwa;
    logic [NUM_CHANNELS*DATA_BITS-1:0] ch_mwd;
    logic [NUM_CONSUMERS-1:0]    wr_req, taken;
    logic [DATA_BITS-1:0]        rdata_q [NUM_CONSUMERS];

    assign wr_req = WRITE_ENABLE != 0 ? consumer_write_valid : '0;

    // lower channels claim first; anything owned or already claimed is skipped
    always_comb begin
        int sel;
        sel   = 0;
        taken = '0;
        for (int c = 0; c < NUM_CHANNELS; c++)
            if (state[c] != S_IDLE) taken[idx[c]] = 1'b1;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            claim[c]      = 1'b0;
            claim_rd[c]   = 1'b0;
            claim_idx[c]  = '0;
            claim_addr[c] = '0;
            claim_data[c] = '0;
            for (int k = 0; k < NUM_CONSUMERS; k++) begin
                sel = (int'(ptr[c]) + k) % NUM_CONSUMERS;
                if (state[c] == S_IDLE && !claim[c] && !taken[sel] &&
                    (consumer_read_valid[sel] || wr_req[sel])) begin
                    claim[c]      = 1'b1;
                    claim_rd[c]   = consumer_read_valid[sel];
                    claim_idx[c]  = IW'(sel);
                    claim_addr[c] = consumer_read_valid[sel] ?
                        consumer_read_address[sel*ADDR_BITS +: ADDR_BITS] :
                        consumer_write_address[sel*ADDR_BITS +: ADDR_BITS];
                    claim_data[c] = consumer_write_data[sel*DATA_BITS +: DATA_BITS];
                    taken[sel]    = 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mem_ctrl_channel #(
            .ADDR_BITS(ADDR_BITS),
            .DATA_BITS(DATA_BITS),
            .NUM_CONSUMERS(NUM_CONSUMERS)
        ) u_ch (
            .clk(clk),
            .rst(rst),
            .claim_i(claim[c]),
            .claim_rd_i(claim_rd[c]),
            .claim_idx_i(claim_idx[c]),
            .claim_addr_i(claim_addr[c]),
            .claim_data_i(claim_data[c]),
            .mem_read_ready_i(mem_read_ready[c]),
            .mem_write_ready_i(mem_write_ready[c]),
            .cons_read_valid_i(consumer_read_valid[idx[c]]),
            .cons_write_valid_i(consumer_write_valid[idx[c]]),
            .state_o(state[c]),
            .ptr_o(ptr[c]),
            .idx_o(idx[c]),
            .mem_read_valid_o(mem_read_valid[c]),
            .mem_write_valid_o(ch_mwv[c]),
            .mem_read_address_o(mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
            .mem_write_address_o(ch_mwa[c*ADDR_BITS +: ADDR_BITS]),
            .mem_write_data_o(ch_mwd[c*DATA_BITS +: DATA_BITS]),
            .read_ready_o(ch_rd_rdy[c]),
            .write_ready_o(ch_wr_rdy[c])
        );
    end

    assign mem_write_valid   = WRITE_ENABLE != 0 ? ch_mwv : '0;
    assign mem_write_address = WRITE_ENABLE != 0 ? ch_mwa : '0;
    assign mem_write_data    = WRITE_ENABLE != 0 ? ch_mwd : '0;

    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_rd_rdy[c]) consumer_read_ready[idx[c]] = 1'b1;
            if (ch_wr_rdy[c] && WRITE_ENABLE != 0) consumer_write_ready[idx[c]] = 1'b1;
        end
    end

    // read data is captured on the same edge that raises the consumer's ready
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_CONSUMERS; j++) rdata_q[j] <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++)
                if (state[c] == S_READ_WAIT && mem_read_ready[c])
                    rdata_q[idx[c]] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
        end
    end

    for (genvar j = 0; j < NUM_CONSUMERS; j++) begin : g_rd
        assign consumer_read_data[j*DATA_BITS +: DATA_BITS] = rdata_q[j];
    end
endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed checks of three controller configurations plus a read-data model
`timescale 1ns/1ps
module tb_mem_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  rv [3], wv [3], rr [3], wr [3], mrv [3], mwv [3];
    logic [31:0] ra [3], wa [3], mra [3], mwa [3];
    logic [63:0] wd [3], rd [3], mwd [3];
    int          lat [3];
    int          vec = 0, errs = 0;
    logic        armed = 1'b0, rst_s = 1'b0;
    logic [15:0] exp_rd [3][4];
    logic [3:0]  rr_p [3];

    function automatic logic [15:0] rom(input logic [7:0] a);
        return a == 8'h15 ? 16'hBEEF : {a, ~a};
    endfunction

    // instance 0: 1 channel; instance 1: 4 channels; instance 2: 1 channel, read-only
    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int NCH = g == 1 ? 4 : 1;
        logic [NCH-1:0]    mrv_l, mwv_l, mrr_l, mwr_l;
        logic [NCH*8-1:0]  mra_l, mwa_l;
        logic [NCH*16-1:0] mwd_l, mrd_l;
        int rc [NCH], wc [NCH];
        mem_controller #(.NUM_CHANNELS(NCH), .WRITE_ENABLE(g == 2 ? 0 : 1)) dut (
            .clk(clk), .rst(rst),
            .consumer_read_valid(rv[g]), .consumer_write_valid(wv[g]),
            .consumer_read_address(ra[g]), .consumer_write_address(wa[g]),
            .consumer_write_data(wd[g]),
            .consumer_read_ready(rr[g]), .consumer_write_ready(wr[g]),
            .consumer_read_data(rd[g]),
            .mem_read_valid(mrv_l), .mem_write_valid(mwv_l),
            .mem_read_address(mra_l), .mem_write_address(mwa_l), .mem_write_data(mwd_l),
            .mem_read_ready(mrr_l), .mem_write_ready(mwr_l), .mem_read_data(mrd_l));
        assign mrv[g] = 4'(mrv_l);
        assign mwv[g] = 4'(mwv_l);
        assign mra[g] = 32'(mra_l);
        assign mwa[g] = 32'(mwa_l);
        assign mwd[g] = 64'(mwd_l);
        // memory answers lat[g] falling edges after it first sees a request
        always @(negedge clk)
            for (int c = 0; c < NCH; c++) begin
                rc[c] = mrv_l[c] ? rc[c] + 1 : 0;
                wc[c] = mwv_l[c] ? wc[c] + 1 : 0;
                mrr_l[c] = mrv_l[c] && rc[c] >= lat[g];
                mwr_l[c] = mwv_l[c] && wc[c] >= lat[g];
                mrd_l[c*16 +: 16] = mrr_l[c] ? rom(mra_l[c*8 +: 8]) : 16'hDEAD;
            end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_rdy(input string nm, input int g, input bit rd_side, input int j, output int n);
        n = 0;
        while (!(rd_side ? rr[g][j] : wr[g][j]) && n < 40) begin
            cyc();
            n++;
        end
        if (n >= 40) chk({nm, "_timeout"}, 64'(n), 64'(0));
    endtask

    task automatic serve(input string nm, input int g, input int j);
        int n = 0;
        while (rr[g] == 4'b0 && n < 40) begin
            cyc();
            n++;
        end
        chk(nm, 64'(rr[g]), 64'(4'b1 << j));
        rv[g][j] = 1'b0;
        cyc();
    endtask

    always @(posedge clk) begin
        rst_s <= rst;
        if (rst) armed <= 1'b1;
    end

    // model: each consumer's read data is the memory word at the address it had when its ready rose
    always @(negedge clk)
        if (armed)
            for (int g = 0; g < 3; g++) begin
                for (int j = 0; j < 4; j++) begin
                    if (rst_s) exp_rd[g][j] = 16'h0;
                    else if (rr[g][j] && !rr_p[g][j]) exp_rd[g][j] = rom(ra[g][j*8 +: 8]);
                    chk($sformatf("rdata_model_g%0d_c%0d", g, j), 64'(rd[g][j*16 +: 16]), 64'(exp_rd[g][j]));
                end
                rr_p[g] = rr[g];
                if (g == 2) chk("ro_write_quiet", 64'({wr[2], mwv[2]}), 64'(0));
            end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        for (int g = 0; g < 3; g++) begin
            rv[g] = '0; wv[g] = '0; ra[g] = '0; wa[g] = '0; wd[g] = '0; lat[g] = 1;
            rr_p[g] = '0;
            for (int j = 0; j < 4; j++) exp_rd[g][j] = '0;
        end
        cyc(2);
        for (int g = 0; g < 3; g++) begin
            chk("reset_flags", 64'({rr[g], wr[g], mrv[g], mwv[g]}), 64'(0));
            chk("reset_rdata", rd[g], 64'(0));
            chk("reset_maddr", 64'({mra[g], mwa[g]}), 64'(0));
            chk("reset_mwdata", mwd[g], 64'(0));
        end
        rst = 1'b0;
        cyc();

        ra[0] = 32'h23222120;
        rv[0] = 4'hF;
        for (int j = 0; j < 4; j++) serve($sformatf("rr_order_r1_%0d", j), 0, j);
        rv[0] = 4'hF;
        for (int j = 0; j < 4; j++) serve($sformatf("rr_order_r2_%0d", j), 0, j);

        lat[0] = 3;
        ra[0] = 32'h00150000;
        rv[0] = 4'b0100;
        cyc();
        chk("r1_mem_valid", 64'(mrv[0]), 64'(1));
        chk("r1_mem_addr", 64'(mra[0]), 64'h15);
        chk("r1_no_ready_yet", 64'(rr[0]), 64'(0));
        wait_rdy("r1", 0, 1'b1, 2, n);
        chk("r1_latency", 64'(n), 64'(3));
        chk("r1_data", 64'(rd[0][32 +: 16]), 64'hBEEF);
        chk("r1_mem_valid_drop", 64'(mrv[0]), 64'(0));
        cyc(2);
        chk("r1_ready_held", 64'(rr[0]), 64'(4'b0100));
        rv[0] = 4'b0;
        cyc();
        chk("r1_ready_clear", 64'(rr[0]), 64'(0));
        chk("r1_data_held", 64'(rd[0][32 +: 16]), 64'hBEEF);

        lat[0] = 1;
        ra[0][8 +: 8] = 8'h31;
        wa[0][8 +: 8] = 8'h32;
        wd[0][16 +: 16] = 16'h1234;
        rv[0] = 4'b0010;
        wv[0] = 4'b0010;
        cyc();
        chk("rw_read_first", 64'({mrv[0], mwv[0]}), 64'(4'b0001 << 4));
        chk("rw_read_addr", 64'(mra[0]), 64'h31);
        wait_rdy("rw_rd", 0, 1'b1, 1, n);
        chk("rw_no_write_ready", 64'(wr[0]), 64'(0));
        rv[0] = 4'b0;
        cyc(2);
        chk("rw_write_valid", 64'(mwv[0]), 64'(1));
        chk("rw_write_addr", 64'(mwa[0]), 64'h32);
        chk("rw_write_data", mwd[0], 64'h1234);
        wait_rdy("rw_wr", 0, 1'b0, 1, n);
        chk("rw_write_ready", 64'(wr[0]), 64'(4'b0010));
        wv[0] = 4'b0;
        cyc();
        chk("rw_write_ready_clear", 64'(wr[0]), 64'(0));

        lat[0] = 3;
        ra[0][24 +: 8] = 8'h40;
        rv[0] = 4'b1000;
        cyc();
        rv[0] = 4'b0;
        wait_rdy("early_drop", 0, 1'b1, 3, n);
        chk("early_drop_data", 64'(rd[0][48 +: 16]), 64'h40BF);
        cyc();
        chk("early_drop_pulse", 64'(rr[0]), 64'(0));

        lat[0] = 5;
        ra[0][7:0] = 8'h60;
        rv[0] = 4'b0001;
        cyc(2);
        chk("rst_mid_waiting", 64'(mrv[0]), 64'(1));
        rst = 1'b1;
        rv[0] = 4'b0;
        cyc();
        rst = 1'b0;
        chk("rst_mid_flags", 64'({rr[0], wr[0], mrv[0], mwv[0]}), 64'(0));
        chk("rst_mid_rdata", rd[0], 64'(0));
        chk("rst_mid_maddr", 64'(mra[0]), 64'(0));
        cyc(3);
        chk("rst_abandoned", 64'({rr[0], mrv[0]}), 64'(0));
        ra[0][7:0] = 8'h61;
        rv[0] = 4'b0001;
        wait_rdy("rst_fresh", 0, 1'b1, 0, n);
        chk("rst_fresh_latency", 64'(n), 64'(6));
        chk("rst_fresh_data", 64'(rd[0][15:0]), 64'h619E);
        rv[0] = 4'b0;
        cyc();

        lat[1] = 2;
        wa[1] = 32'h53525150;
        wd[1] = 64'hA003A002A001A000;
        wv[1] = 4'hF;
        cyc();
        chk("w4_all_valid", 64'(mwv[1]), 64'hF);
        chk("w4_addr_map", 64'(mwa[1]), 64'h53525150);
        chk("w4_data_map", mwd[1], 64'hA003A002A001A000);
        n = 0;
        while (wr[1] != 4'hF && n < 40) begin
            cyc();
            n++;
        end
        chk("w4_all_ready", 64'(wr[1]), 64'hF);
        wv[1] = 4'b0;
        cyc();
        chk("w4_ready_clear", 64'(wr[1]), 64'(0));
        ra[1] = 32'h73727170;
        rv[1] = 4'hF;
        cyc();
        chk("r4_ptr_addr_map", 64'(mra[1]), 64'h70737271);
        n = 0;
        while (rr[1] != 4'hF && n < 40) begin
            cyc();
            n++;
        end
        chk("r4_all_ready", 64'(rr[1]), 64'hF);
        rv[1] = 4'b0;
        cyc();

        wa[2] = 32'h00000077;
        wd[2] = 64'h5555;
        wv[2] = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("ro_no_write", 64'({wr[2], mwv[2]}), 64'(0));
        end
        ra[2] = 32'h00000015;
        rv[2] = 4'b0001;
        wait_rdy("ro_read", 2, 1'b1, 0, n);
        chk("ro_read_data", 64'(rd[2][15:0]), 64'hBEEF);
        rv[2] = 4'b0;
        wv[2] = 4'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
